// File: rtl/dispatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// dispatch_ctrl_if
// Bundle of the decode-side and issue-side signals of the dispatch controller.
//   decode side : in_valid/in_ready handshake, in_uop payload, FU-class flags,
//                 in_rd / in_opcode (for physical-register qualification)
//   control     : flush, freelist_empty
//   issue side  : out_uop shared payload, alu/mem/br valid/ready handshakes,
//                 preg_alloc and illegal pulses, stall_cnt performance counter
// Modports:
//   slave  - the dispatch controller itself
//   master - the surrounding pipeline (decode, rename, issue queues)
// -----------------------------------------------------------------------------
interface dispatch_ctrl_if #(
  parameter int UOP_W = 35
);
  logic             in_valid;
  logic             in_ready;
  logic [UOP_W-1:0] in_uop;
  logic             in_fu_alu;
  logic             in_fu_mem;
  logic             in_fu_br;
  logic [4:0]       in_rd;
  logic [6:0]       in_opcode;
  logic             flush;
  logic             freelist_empty;
  logic [UOP_W-1:0] out_uop;
  logic             alu_valid;
  logic             alu_ready;
  logic             mem_valid;
  logic             mem_ready;
  logic             br_valid;
  logic             br_ready;
  logic             preg_alloc;
  logic             illegal;
  logic [15:0]      stall_cnt;

  modport slave (
    input  in_valid, in_uop, in_fu_alu, in_fu_mem, in_fu_br, in_rd, in_opcode,
    input  flush, freelist_empty,
    input  alu_ready, mem_ready, br_ready,
    output in_ready, out_uop, alu_valid, mem_valid, br_valid,
    output preg_alloc, illegal, stall_cnt
  );

  modport master (
    output in_valid, in_uop, in_fu_alu, in_fu_mem, in_fu_br, in_rd, in_opcode,
    output flush, freelist_empty,
    output alu_ready, mem_ready, br_ready,
    input  in_ready, out_uop, alu_valid, mem_valid, br_valid,
    input  preg_alloc, illegal, stall_cnt
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// dispatch_ctrl
// Buffers decoded uops in a small in-order FIFO and routes the head uop to
// exactly one of the ALU, MEM or BR issue queues over valid/ready.
// Dispatch stalls when the selected queue is not ready or when the uop needs
// a physical register and the rename free list is empty. Uops without any
// FU-class flag are dropped with a one-cycle illegal pulse. Flush empties the
// buffer; a saturating counter records cycles in which a valid head stalls.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - dispatch_ctrl_if.slave (decode, rename and issue-queue signals)
// -----------------------------------------------------------------------------
module dispatch_ctrl #(
  parameter int DEPTH = 2,
  parameter int UOP_W = 35
) (
  input logic            clk,
  input logic            rst_n,
  dispatch_ctrl_if.slave bus
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  // Stores and branches carry rs2/imm bits in the rd field, so they never
  // claim a physical register; neither does a write to x0.
  function automatic logic calc_needs_preg(input logic [4:0] rd,
                                           input logic [6:0] opcode);
    return (rd != 5'd0) && (opcode != OPC_STORE) && (opcode != OPC_BRANCH);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // Entry storage
  logic [UOP_W-1:0] uop_q [DEPTH];
  logic [DEPTH-1:0] fu_alu_q;
  logic [DEPTH-1:0] fu_mem_q;
  logic [DEPTH-1:0] fu_br_q;
  logic [DEPTH-1:0] needs_preg_q;

  // Control state
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;
  logic [15:0]      stall_q;

  // Head decode and handshake terms
  logic head_vld;
  logic h_alu;
  logic h_mem;
  logic h_br;
  logic h_np;
  logic h_illegal;
  logic h_blocked;
  logic offer;
  logic alu_v;
  logic mem_v;
  logic br_v;
  logic fire;
  logic in_rdy;
  logic enq;
  logic deq;
  logic stall;

  always_comb begin
    head_vld  = (count != '0);
    h_alu     = fu_alu_q[head];
    h_mem     = fu_mem_q[head];
    h_br      = fu_br_q[head];
    h_np      = needs_preg_q[head];
    h_illegal = head_vld && !(h_alu || h_mem || h_br);
    h_blocked = h_np && bus.freelist_empty;

    // A legal, unblocked head is offered to exactly one queue. BR wins over
    // MEM, MEM over ALU, so loads/stores (ALU+MEM) land in the MEM queue.
    offer = head_vld && !bus.flush && !h_blocked && !h_illegal;
    br_v  = offer && h_br;
    mem_v = offer && !h_br && h_mem;
    alu_v = offer && !h_br && !h_mem && h_alu;

    fire  = (br_v && bus.br_ready) || (mem_v && bus.mem_ready) ||
            (alu_v && bus.alu_ready);

    // in_ready is a pure function of occupancy and flush: no path from the
    // issue-queue ready lines back to decode, so a full buffer refuses input
    // even in a cycle where the head leaves.
    in_rdy = (count < DEPTH_C) && !bus.flush;
    enq    = bus.in_valid && in_rdy;

    // Illegal heads leave without a handshake and regardless of the free list.
    deq    = !bus.flush && (fire || h_illegal);
    stall  = head_vld && !deq && !bus.flush;
  end

  assign bus.in_ready   = in_rdy;
  assign bus.alu_valid  = alu_v;
  assign bus.mem_valid  = mem_v;
  assign bus.br_valid   = br_v;
  assign bus.preg_alloc = fire && h_np;
  assign bus.illegal    = h_illegal && !bus.flush;
  assign bus.out_uop    = uop_q[head];
  assign bus.stall_cnt  = stall_q;

  // Register stage: FIFO pointers, occupancy, entry write and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      stall_q      <= '0;
      fu_alu_q     <= '0;
      fu_mem_q     <= '0;
      fu_br_q      <= '0;
      needs_preg_q <= '0;
      // Cleared so out_uop shows zero rather than X after reset.
      for (int i = 0; i < DEPTH; i++) begin
        uop_q[i] <= '0;
      end
    end else begin
      if (stall) begin
        stall_q <= sat_inc16(stall_q);
      end

      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          uop_q[tail]        <= bus.in_uop;
          fu_alu_q[tail]     <= bus.in_fu_alu;
          fu_mem_q[tail]     <= bus.in_fu_mem;
          fu_br_q[tail]      <= bus.in_fu_br;
          needs_preg_q[tail] <= calc_needs_preg(bus.in_rd, bus.in_opcode);
          tail               <= tail + AW'(1);
        end
        if (deq) begin
          head <= head + AW'(1);
        end
        case ({enq, deq})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dispatch_ctrl
// Directed vector table for the dispatch scenarios, an asynchronous-reset
// sequence, and a randomized run compared against a queue-based model.
// -----------------------------------------------------------------------------
module tb_dispatch_ctrl;
  localparam int DEPTH = 2;
  localparam int UOP_W = 35;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_ADDI   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_UNK    = 7'b1111111;

  // FU flag and ready encodings: {br, mem, alu}
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_ALU  = 3'b001;
  localparam logic [2:0] F_MEM  = 3'b010;
  localparam logic [2:0] F_LDST = 3'b011;
  localparam logic [2:0] F_BR   = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dispatch_ctrl_if #(.UOP_W(UOP_W)) bus ();

  dispatch_ctrl #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [2:0] fu, input logic [4:0] rd,
                       input logic [6:0] opc, input logic [UOP_W-1:0] uop,
                       input logic fl, input logic fe, input logic [2:0] rdy);
    bus.in_valid       = iv;
    bus.in_fu_alu      = fu[0];
    bus.in_fu_mem      = fu[1];
    bus.in_fu_br       = fu[2];
    bus.in_rd          = rd;
    bus.in_opcode      = opc;
    bus.in_uop         = uop;
    bus.flush          = fl;
    bus.freelist_empty = fe;
    bus.alu_ready      = rdy[0];
    bus.mem_ready      = rdy[1];
    bus.br_ready       = rdy[2];
  endtask

  // {in_ready, alu_valid, mem_valid, br_valid, preg_alloc, illegal}
  function automatic logic [5:0] obs();
    return {bus.in_ready, bus.alu_valid, bus.mem_valid, bus.br_valid,
            bus.preg_alloc, bus.illegal};
  endfunction

  typedef struct {
    logic             iv;
    logic [2:0]       fu;
    logic [4:0]       rd;
    logic [6:0]       opc;
    logic [UOP_W-1:0] uop;
    logic             fl;
    logic             fe;
    logic [2:0]       rdy;
    logic [5:0]       eo;
    logic [15:0]      esc;
    logic             cu;
    logic [UOP_W-1:0] eu;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic iv, input logic [2:0] fu, input logic [4:0] rd,
                      input logic [6:0] opc, input logic [UOP_W-1:0] uop,
                      input logic fl, input logic fe, input logic [2:0] rdy,
                      input logic [5:0] eo, input logic [15:0] esc,
                      input logic cu, input logic [UOP_W-1:0] eu);
    vec_t v;
    v.iv = iv; v.fu = fu; v.rd = rd; v.opc = opc; v.uop = uop;
    v.fl = fl; v.fe = fe; v.rdy = rdy; v.eo = eo; v.esc = esc;
    v.cu = cu; v.eu = eu;
    tbl.push_back(v);
  endtask

  // Reference model state
  typedef struct {
    logic [UOP_W-1:0] uop;
    bit               alu;
    bit               mem;
    bit               br;
    bit               np;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] msc;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  localparam logic [UOP_W-1:0] UA = 35'h1_0000_00A1, UB = 35'h2_0000_00B2,
                               UC = 35'h3_0000_00C3, UD = 35'h4_0000_00D4,
                               UE = 35'h5_0000_00E5, UF = 35'h6_0000_00F6,
                               UG = 35'h7_0000_0017, UH = 35'h1_1111_0028,
                               UI = 35'h2_2222_0039, UJ = 35'h3_3333_004A,
                               UK = 35'h4_4444_005B, UL = 35'h5_5555_006C,
                               UM = 35'h6_6666_007D;

  initial begin
    logic [63:0] rnd;
    logic [5:0]  eo;
    bit          deq;
    bit          ill;
    bit          preg;
    bit          rdy_e;
    bit [2:0]    vld;
    int          tgt;
    ent_t        h;
    ent_t        ne;
    logic        r_iv, r_fl, r_fe;
    logic [2:0]  r_fu, r_rdy;
    logic [4:0]  r_rd;
    logic [6:0]  r_opc;
    logic [UOP_W-1:0] r_uop;
    int          sel;

    // iv fu rd opc uop fl fe rdy | eo(rdy,a,m,b,pa,il) sc cu eu
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b000, 6'b100000, 0, 0, '0);
    addv(1, F_ALU,  5, OPC_R,      UA, 0, 0, 3'b001, 6'b100000, 0, 0, '0);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b001, 6'b110010, 0, 1, UA);
    addv(1, F_LDST, 7, OPC_LOAD,   UB, 0, 0, 3'b000, 6'b100000, 0, 0, '0);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b001, 6'b101000, 0, 1, UB);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b001, 6'b101000, 1, 1, UB);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b000, 6'b101000, 2, 1, UB);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b010, 6'b101010, 3, 1, UB);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b000, 6'b100000, 3, 0, '0);
    addv(1, F_BR,   0, OPC_BRANCH, UC, 0, 0, 3'b000, 6'b100000, 3, 0, '0);
    addv(1, F_ALU,  1, OPC_R,      UD, 0, 0, 3'b000, 6'b100100, 3, 1, UC);
    addv(1, F_ALU,  6, OPC_R,      UE, 0, 0, 3'b000, 6'b000100, 4, 1, UC);
    addv(1, F_ALU,  6, OPC_R,      UE, 0, 0, 3'b100, 6'b000100, 5, 1, UC);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b000, 6'b110000, 5, 1, UD);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b001, 6'b110010, 6, 1, UD);
    addv(1, F_ALU,  3, OPC_ADDI,   UF, 0, 1, 3'b001, 6'b100000, 6, 0, '0);
    addv(1, F_LDST, 9, OPC_STORE,  UG, 0, 1, 3'b001, 6'b100000, 6, 1, UF);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 1, 3'b011, 6'b000000, 7, 1, UF);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b011, 6'b010010, 8, 1, UF);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 1, 3'b011, 6'b101000, 8, 1, UG);
    addv(1, F_NONE, 4, OPC_UNK,    UH, 0, 0, 3'b111, 6'b100000, 8, 0, '0);
    addv(1, F_ALU,  2, OPC_R,      UI, 0, 0, 3'b111, 6'b100001, 8, 1, UH);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b111, 6'b110010, 8, 1, UI);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b000, 6'b100000, 8, 0, '0);
    addv(1, F_ALU,  1, OPC_R,      UJ, 0, 0, 3'b000, 6'b100000, 8, 0, '0);
    addv(1, F_LDST, 2, OPC_LOAD,   UK, 0, 0, 3'b000, 6'b110000, 8, 1, UJ);
    addv(1, F_ALU,  1, OPC_R,      UL, 1, 0, 3'b000, 6'b000000, 9, 0, '0);
    addv(0, F_NONE, 0, OPC_R,      '0, 0, 0, 3'b111, 6'b100000, 9, 0, '0);

    // Reset state, sampled while reset is held
    drive(0, F_NONE, 0, OPC_R, '0, 0, 0, 3'b000);
    @(negedge clk);
    chk("reset.outs", 64'(obs()), 64'(6'b100000));
    chk("reset.stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("reset.out_uop", 64'(bus.out_uop), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].fu, tbl[i].rd, tbl[i].opc, tbl[i].uop,
            tbl[i].fl, tbl[i].fe, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d.outs", i), 64'(obs()), 64'(tbl[i].eo));
      chk($sformatf("vec%0d.stall_cnt", i), 64'(bus.stall_cnt), 64'(tbl[i].esc));
      if (tbl[i].cu) chk($sformatf("vec%0d.out_uop", i), 64'(bus.out_uop), 64'(tbl[i].eu));
      @(posedge clk);
      #1;
    end

    // Stall an ALU head, then pull reset between clock edges
    drive(1, F_ALU, 1, OPC_R, UM, 0, 0, 3'b000);
    @(posedge clk);
    #1 drive(0, F_NONE, 0, OPC_R, '0, 0, 0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_before_reset", 64'(bus.stall_cnt), 64'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset.stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("async_reset.outs", 64'(obs()), 64'(6'b100000));
    chk("async_reset.out_uop", 64'(bus.out_uop), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized run against the queue model
    mq.delete();
    msc = '0;
    for (int c = 0; c < 1500; c++) begin
      r_iv = ($urandom_range(0, 9) < 6);
      sel  = $urandom_range(0, 9);
      case (sel)
        0:       r_fu = F_NONE;
        1, 2, 3: r_fu = F_ALU;
        4, 5:    r_fu = F_LDST;
        6, 7:    r_fu = F_BR;
        8:       r_fu = F_MEM;
        default: r_fu = 3'($urandom_range(0, 7));
      endcase
      case ($urandom_range(0, 5))
        0:       r_opc = OPC_R;
        1:       r_opc = OPC_ADDI;
        2:       r_opc = OPC_LOAD;
        3:       r_opc = OPC_STORE;
        4:       r_opc = OPC_BRANCH;
        default: r_opc = OPC_UNK;
      endcase
      r_rd  = ($urandom_range(0, 9) < 3) ? 5'd0 : 5'($urandom_range(1, 31));
      rnd   = {$urandom, $urandom};
      r_uop = rnd[UOP_W-1:0];
      r_fl  = ($urandom_range(0, 19) == 0);
      r_fe  = ($urandom_range(0, 4) == 0);
      r_rdy = 3'($urandom_range(0, 7));
      drive(r_iv, r_fu, r_rd, r_opc, r_uop, r_fl, r_fe, r_rdy);
      @(negedge clk);

      rdy_e = (mq.size() < DEPTH) && !r_fl;
      vld = 3'b000; deq = 0; ill = 0; preg = 0;
      if (mq.size() > 0 && !r_fl) begin
        h = mq[0];
        if (!h.alu && !h.mem && !h.br) begin
          ill = 1;
          deq = 1;
        end else if (!(h.np && r_fe)) begin
          tgt = h.br ? 2 : (h.mem ? 1 : 0);
          vld[tgt] = 1'b1;
          if (r_rdy[tgt]) begin
            deq  = 1;
            preg = h.np;
          end
        end
      end
      eo = {rdy_e, vld[0], vld[1], vld[2], preg, ill};
      chk($sformatf("rnd%0d.outs", c), 64'(obs()), 64'(eo));
      chk($sformatf("rnd%0d.stall_cnt", c), 64'(bus.stall_cnt), 64'(msc));
      if (mq.size() > 0 && !r_fl)
        chk($sformatf("rnd%0d.out_uop", c), 64'(bus.out_uop), 64'(mq[0].uop));

      if (mq.size() > 0 && !deq && !r_fl && msc != 16'hFFFF) msc = msc + 16'd1;
      if (r_fl) begin
        mq.delete();
      end else begin
        if (deq) void'(mq.pop_front());
        if (r_iv && rdy_e) begin
          ne.uop = r_uop;
          ne.alu = r_fu[0];
          ne.mem = r_fu[1];
          ne.br  = r_fu[2];
          ne.np  = (r_rd != 0) && (r_opc != OPC_STORE) && (r_opc != OPC_BRANCH);
          mq.push_back(ne);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

Decoded-micro-op dispatch controller between the decode stage and the three issue queues (ALU, MEM, BR). Each decoded uop and its FU-class flags are buffered in a small in-order FIFO. The head uop is routed to exactly one issue queue over a valid/ready handshake, and dispatch stalls when the target queue is full or a destination physical register is unavailable. The block also owns pipeline flush of the decode-to-issue boundary and a saturating stall counter for performance analysis.

## Interface
- DEPTH, 2: buffer entries; power of two, at least 2.
- UOP_W, 35: opaque uop payload width ({func7, func3, opcode, ALUOp, rd, rs2, rs1}).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents a uop.
- in_ready  out  1  buffer can accept this cycle.
- in_uop  in  UOP_W  decoded payload.
- in_fu_alu, in_fu_mem, in_fu_br  in  1 each  FU-class flags from decode.
- in_rd  in  5  destination architectural register.
- in_opcode  in  7  opcode, used for the writes-rd qualification.
- flush  in  1  discard all buffered uops.
- freelist_empty  in  1  rename has no free physical register.
- out_uop  out  UOP_W  head payload, shared by all three queues.
- alu_valid / alu_ready  out / in  1  ALU issue-queue handshake.
- mem_valid / mem_ready  out / in  1  MEM issue-queue handshake.
- br_valid / br_ready  out / in  1  BR issue-queue handshake.
- preg_alloc  out  1  one-cycle pulse: the dispatched uop consumes a physical register.
- illegal  out  1  one-cycle pulse: head uop had no FU flag set and was dropped.
- stall_cnt  out  16  saturating count of stalled head cycles.

## Operation
- Buffer: circular FIFO with head and tail pointers of log2(DEPTH) bits that wrap naturally, plus a count register of log2(DEPTH)+1 bits.
- Each entry stores the payload, all three FU flags, and a needs_preg bit.
- needs_preg = (in_rd != 0) and in_opcode is neither 0100011 (store) nor 1100011 (branch). It is computed at enqueue.
- Enqueue: when in_valid and in_ready are both high.
- Routing of the head uop, priority order: fu_br goes to BR; otherwise fu_mem goes to MEM; otherwise fu_alu goes to ALU. Loads and stores carry both fu_alu and fu_mem and go to MEM.
- At most one *_valid is high per cycle.
- The head is blocked when needs_preg and freelist_empty are both high; in that case every *_valid is 0.
- Dispatch (dequeue) happens when the selected *_valid and its *_ready are both high.
- preg_alloc is high in the same cycle as a dispatch whose needs_preg bit is set.
- Illegal head (no FU flag set): no *_valid is driven. The entry is dequeued unconditionally that cycle with illegal = 1.
- Stall: the head is valid, not dequeued this cycle, and flush = 0. stall_cnt increments and holds at 0xFFFF. It clears only on reset.
- Flush has priority over everything:
  - in_ready = 0, all *_valid = 0, preg_alloc = 0, illegal = 0 in the flush cycle.
  - Pointers and count clear at the next edge; no enqueue or dequeue takes effect.
- Reset, asynchronous:
  - Pointers, count and stall_cnt go to 0.
  - in_ready = 1, all *_valid = 0, preg_alloc = 0, illegal = 0, out_uop = 0.
  - Any uop in flight is discarded.

## Timing
- in_ready = (count < DEPTH) and !flush.
  - It does not depend on any *_ready (no combinational path from the issue queues to decode).
  - When full, enqueue is blocked even if the head dispatches that cycle.
- Latency: a uop enqueued at edge N is presented on *_valid in cycle N+1 at the earliest. The minimum decode-to-issue latency is 1 cycle.
- Throughput: 1 uop per cycle in steady state while count < DEPTH.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Empty: no *_valid, illegal = 0, and stall_cnt holds.
- out_uop is driven from the head entry register. It is stable while the head is stalled and undefined-but-held when empty; drive the last head value, no X.
- *_valid must not drop without a handshake except on flush or reset.
- The payload must not change while any *_valid is high and its *_ready is low.

## Test plan
- Reset, then enqueue R-type (fu_alu, rd = 5) with alu_ready = 1. Required: alu_valid in the next cycle with out_uop equal to the input, preg_alloc = 1; stall_cnt = 0.
- Enqueue a load (fu_alu + fu_mem) with mem_ready = 0 for 3 cycles, then 1. Required: mem_valid held 4 cycles, alu_valid = 0 throughout, stall_cnt = 3, a single dispatch.
- Fill DEPTH = 2 with both ready lines low. Required: in_ready = 0. Raise br_ready on a branch head (rd field = 0). Required: dispatch with preg_alloc = 0, in_ready returns to 1 the next cycle, and FIFO order is preserved across pointer wrap over 6 uops.
- Head is an ADDI with rd = 3 and freelist_empty = 1 for 2 cycles. Required: all *_valid = 0 and stall_cnt += 2. Head is a store under the same freelist_empty = 1. Required: it dispatches immediately.
- Enqueue an unknown opcode (no flags) followed by an ALU uop. Required: illegal pulses 1 cycle, the ALU uop dispatches the cycle after, no *_valid is raised for the illegal entry.
- Full buffer, assert flush one cycle coincident with in_valid. Required: all valid lines = 0, the uop is not accepted, count = 0 after the edge. Then assert rst_n low mid-stall. Required: stall_cnt = 0 immediately, without waiting for a clock edge.
